// File: rtl/core_run_ctrl.sv
// Run controller for an attached core: holds it in reset, releases it, and watches
// its output bus until it settles. Optional watchdog: CORE_RUN_CTRL_WATCHDOG_EN.
module core_run_ctrl #(
  parameter int RST_CYCLES    = 5,
  parameter int STABLE_CYCLES = 8,
  parameter int MAX_CYCLES    = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [9:0]  core_out,
  output logic        core_reset,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [9:0]  result,
  output logic [15:0] cycles,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);
  localparam logic [7:0] STAB_TGT = 8'(STABLE_CYCLES);
`ifdef CORE_RUN_CTRL_WATCHDOG_EN
  localparam logic [15:0] MAX_CYC = 16'(MAX_CYCLES);
`endif

  generate
    if (RST_CYCLES < 1 || RST_CYCLES > 255) begin : g_bad_rst
      $error("RST_CYCLES out of range 1..255");
    end
    if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255) begin : g_bad_stab
      $error("STABLE_CYCLES out of range 2..255");
    end
    if (MAX_CYCLES < 1 || MAX_CYCLES > 65535) begin : g_bad_max
      $error("MAX_CYCLES out of range 1..65535");
    end
  endgenerate

  state_t      state_q, state_d;
  logic [7:0]  rst_cnt_q, rst_cnt_d;
  logic [7:0]  stab_cnt_q, stab_cnt_d;
  logic [9:0]  prev_out_q, prev_out_d;
  logic [15:0] cycles_q, cycles_d;
  logic [9:0]  result_q, result_d;
  logic        timeout_q, timeout_d;
  logic        core_reset_q, core_reset_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [7:0]  stab_next;
  logic [15:0] cycles_inc;

  always_comb begin
    // A zero stability count marks the first RUN edge of a run.
    if (stab_cnt_q == 8'd0) begin
      stab_next = 8'd1;
    end else if (core_out == prev_out_q) begin
      stab_next = stab_cnt_q + 8'd1;
    end else begin
      stab_next = 8'd1;
    end
    cycles_inc = (cycles_q == 16'hFFFF) ? cycles_q : cycles_q + 16'd1;
  end

  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    stab_cnt_d = stab_cnt_q;
    prev_out_d = prev_out_q;
    cycles_d   = cycles_q;
    result_d   = result_q;
    timeout_d  = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RESET;
          rst_cnt_d  = 8'd0;
          stab_cnt_d = 8'd0;
          cycles_d   = 16'd0;
          timeout_d  = 1'b0;
        end
      end
      S_RESET: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (rst_cnt_q == RST_LAST) begin
          state_d = S_RUN;
        end else begin
          rst_cnt_d = rst_cnt_q + 8'd1;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          cycles_d   = cycles_inc;
          stab_cnt_d = stab_next;
          prev_out_d = core_out;
          // Stability is tested first so it beats a same-edge watchdog expiry.
          if (stab_next == STAB_TGT) begin
            state_d   = S_DONE;
            result_d  = core_out;
            timeout_d = 1'b0;
          end
`ifdef CORE_RUN_CTRL_WATCHDOG_EN
          else if (cycles_inc >= MAX_CYC) begin
            state_d   = S_DONE;
            result_d  = core_out;
            timeout_d = 1'b1;
          end
`endif
        end
      end
      S_DONE: begin
        if (abort) begin
          state_d   = S_IDLE;
          timeout_d = 1'b0;
        end else if (start) begin
          state_d    = S_RESET;
          rst_cnt_d  = 8'd0;
          stab_cnt_d = 8'd0;
          cycles_d   = 16'd0;
          timeout_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifndef CORE_RUN_CTRL_WATCHDOG_EN
    timeout_d = 1'b0;
`endif
    core_reset_d = (state_d != S_RUN);
    busy_d       = (state_d == S_RESET) || (state_d == S_RUN);
    done_d       = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rst_cnt_q    <= 8'd0;
      stab_cnt_q   <= 8'd0;
      prev_out_q   <= 10'd0;
      cycles_q     <= 16'd0;
      result_q     <= 10'd0;
      timeout_q    <= 1'b0;
      core_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rst_cnt_q    <= rst_cnt_d;
      stab_cnt_q   <= stab_cnt_d;
      prev_out_q   <= prev_out_d;
      cycles_q     <= cycles_d;
      result_q     <= result_d;
      timeout_q    <= timeout_d;
      core_reset_q <= core_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign core_reset = core_reset_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign timeout    = timeout_q;
  assign result     = result_q;
  assign cycles     = cycles_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl: a vector table for the main run flows plus a
// hand-written watchdog / long-run sequence.
module tb_core_run_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [9:0]  core_out;
  logic        core_reset;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [9:0]  result;
  logic [15:0] cycles;
  logic [1:0]  dbg_state;

  int n_tests;
  int n_fail;

  typedef struct {
    logic        rst;
    logic        st;
    logic        ab;
    logic [9:0]  co;
    logic        e_cr;
    logic        e_busy;
    logic        e_done;
    logic        e_to;
    logic [9:0]  e_res;
    logic [15:0] e_cyc;
  } vec_t;

  vec_t vq[$];

  core_run_ctrl #(
    .RST_CYCLES(5),
    .STABLE_CYCLES(8),
    .MAX_CYCLES(1000)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .abort(abort),
    .core_out(core_out),
    .core_reset(core_reset),
    .busy(busy),
    .done(done),
    .timeout(timeout),
    .result(result),
    .cycles(cycles),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic void add(input logic rst, input logic st, input logic ab,
                              input logic [9:0] co, input logic e_cr,
                              input logic e_busy, input logic e_done,
                              input logic e_to, input logic [9:0] e_res,
                              input logic [15:0] e_cyc);
    vec_t v;
    v.rst = rst; v.st = st; v.ab = ab; v.co = co;
    v.e_cr = e_cr; v.e_busy = e_busy; v.e_done = e_done; v.e_to = e_to;
    v.e_res = e_res; v.e_cyc = e_cyc;
    vq.push_back(v);
  endfunction

  // driver: present inputs at the falling edge, sample 1 time unit after the rising edge
  task automatic step(input logic rst, input logic st, input logic ab, input logic [9:0] co);
    @(negedge clk);
    reset    = rst;
    start    = st;
    abort    = ab;
    core_out = co;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input logic [15:0] act,
                       input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input vec_t v);
    check("core_reset", idx, {15'd0, core_reset}, {15'd0, v.e_cr});
    check("busy",       idx, {15'd0, busy},       {15'd0, v.e_busy});
    check("done",       idx, {15'd0, done},       {15'd0, v.e_done});
    check("timeout",    idx, {15'd0, timeout},    {15'd0, v.e_to});
    check("result",     idx, {6'd0, result},      {6'd0, v.e_res});
    check("cycles",     idx, cycles,              v.e_cyc);
  endtask

  function automatic logic [9:0] tog(input int i);
    return (i % 2 == 1) ? 10'h2AA : 10'h155;
  endfunction

  initial begin
    vec_t v;
    n_tests  = 0;
    n_fail   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    core_out = 10'd0;

    // reset for 2 cycles, start asserted to confirm reset priority
    add(1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    // start -> five RESET cycles, then RUN with core_reset low
    add(0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    // core_out counts 0..19, then holds 20 until eight equal samples
    for (int i = 0; i < 20; i++) add(0, 0, 0, 10'(i), 0, 1, 0, 0, 0, 16'(i + 1));
    for (int i = 0; i < 7; i++)  add(0, 0, 0, 20, 0, 1, 0, 0, 0, 16'(21 + i));
    add(0, 0, 0, 20, 1, 0, 1, 0, 20, 28);
    add(0, 0, 0, 5,  1, 0, 1, 0, 20, 28);
    // start from DONE restarts, result held
    add(0, 1, 0, 5, 1, 1, 0, 0, 20, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 1, 1, 0, 0, 20, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 20, 0);
    for (int i = 0; i < 10; i++) add(0, 0, 0, tog(i), 0, 1, 0, 0, 20, 16'(i + 1));
    // abort with start in the same cycle: abort wins
    add(0, 1, 1, 10'h155, 1, 0, 0, 0, 20, 10);
    add(0, 0, 0, 10'h155, 1, 0, 0, 0, 20, 10);
    // reset mid-RUN, then a full restart
    add(0, 1, 0, 0, 1, 1, 0, 0, 20, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 1, 1, 0, 0, 20, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 20, 0);
    for (int i = 0; i < 3; i++) add(0, 0, 0, tog(i), 0, 1, 0, 0, 20, 16'(i + 1));
    add(1, 1, 1, 10'h155, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 7, 0, 1, 0, 0, 0, 1);
    // abort mid-RESET
    add(0, 0, 1, 7, 1, 0, 0, 0, 0, 1);
    add(0, 1, 0, 7, 1, 1, 0, 0, 0, 0);
    add(0, 0, 1, 7, 1, 0, 0, 0, 0, 0);

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      step(v.rst, v.st, v.ab, v.co);
      check_all(i, v);
    end

    // long run with a toggling bus: watchdog ends it, or it keeps running
    step(0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    check("run_entry_core_reset", 900, {15'd0, core_reset}, 16'd0);
`ifdef CORE_RUN_CTRL_WATCHDOG_EN
    for (int i = 0; i < 999; i++) step(0, 0, 0, tog(i));
    check("wd_busy_999",  999, {15'd0, busy}, 16'd1);
    check("wd_done_999",  999, {15'd0, done}, 16'd0);
    step(0, 0, 0, tog(999));
    check("wd_done",      1000, {15'd0, done},    16'd1);
    check("wd_timeout",   1000, {15'd0, timeout}, 16'd1);
    check("wd_busy",      1000, {15'd0, busy},    16'd0);
    check("wd_cycles",    1000, cycles,           16'd1000);
    check("wd_result",    1000, {6'd0, result},   16'h2AA);
`else
    for (int i = 0; i < 2000; i++) step(0, 0, 0, tog(i));
    check("nowd_busy",    2000, {15'd0, busy},       16'd1);
    check("nowd_done",    2000, {15'd0, done},       16'd0);
    check("nowd_timeout", 2000, {15'd0, timeout},    16'd0);
    check("nowd_cycles",  2000, cycles,              16'd2000);
    check("nowd_core_rst", 2000, {15'd0, core_reset}, 16'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/core_run_ctrl.md
CORE_RUN_CTRL -- requirements
Module: core_run_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 5: number of clk cycles core_reset is held in RESET (legal range 1..255).
REQ-002 Parameter STABLE_CYCLES, default 8: number of consecutive equal core_out samples that declares completion (legal range 2..255).
REQ-003 Parameter MAX_CYCLES, default 1000: watchdog budget in RUN cycles (legal range 1..65535); used only with CORE_RUN_CTRL_WATCHDOG_EN.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  single-cycle run request.
REQ-007 abort  input  1  cancel the current run.
REQ-008 core_out  input  10  core output bus being monitored.
REQ-009 core_reset  output  1  active-high reset driven to the core.
REQ-010 busy  output  1  high in the RESET and RUN states.
REQ-011 done  output  1  high in the DONE state.
REQ-012 timeout  output  1  run ended by the watchdog; valid while done is high.
REQ-013 result  output  10  captured final core_out value.
REQ-014 cycles  output  16  count of RUN cycles in the current or last run.

Function
REQ-015 The FSM SHALL have the states IDLE, RESET, RUN and DONE; all outputs are registered.
REQ-016 IDLE: core_reset=1, busy=0; start moves the FSM to RESET, and IDLE is left on the next edge.
REQ-017 Leaving IDLE or DONE on start SHALL, on the same edge, clear done, timeout, cycles and the stability counter, and SHALL hold result.
REQ-018 RESET: core_reset=1 for exactly RST_CYCLES cycles, then the FSM moves to RUN; the first RUN cycle drives core_reset=0.
REQ-019 RUN: cycles increments on each RUN edge and saturates at 16'hFFFF.
REQ-020 Stability tracking in RUN: the first RUN edge loads prev_out<=core_out and stab_cnt<=1; each later edge sets stab_cnt+1 if core_out==prev_out, else 1, then loads prev_out<=core_out.
REQ-021 When the updated stab_cnt equals STABLE_CYCLES, on that edge the FSM SHALL move to DONE with result<=core_out and timeout<=0.
REQ-022 DONE: done=1, busy=0, core_reset=1; outputs are held until start, abort or reset.
REQ-023 start in DONE SHALL restart the sequence at RESET (REQ-017 applies); start in RESET or RUN SHALL be ignored.
REQ-024 abort in RESET, RUN or DONE SHALL move the FSM to IDLE on the next edge, clear done and timeout, and hold result and cycles.
REQ-025 abort and start asserted in the same cycle: abort wins.
REQ-026 Stability completion and watchdog expiry on the same edge: completion wins and timeout=0.

Reset
REQ-027 On reset, state=IDLE, core_reset=1, busy=0, done=0, timeout=0, result=0, cycles=0, stab_cnt=0 and prev_out=0.
REQ-028 reset SHALL take priority over start and abort in every state, including mid-RESET and mid-RUN.

Configuration
REQ-029 Macro CORE_RUN_CTRL_WATCHDOG_EN defined: when cycles reaches MAX_CYCLES in RUN, the FSM moves to DONE with timeout=1 and result<=core_out on that edge.
REQ-030 Macro CORE_RUN_CTRL_WATCHDOG_EN undefined: no watchdog logic, timeout is tied to 0, and RUN ends only on stability, abort or reset.

Verification
REQ-031 Apply reset for 2 cycles -> core_reset=1, busy=0, done=0, timeout=0, result=0, cycles=0.
REQ-032 Pulse start in IDLE -> busy=1 next cycle, core_reset=1 for exactly 5 cycles, then core_reset=0.
REQ-033 In RUN, core_out counts 0..19 and then holds 20 -> done=1 after the 8th consecutive sample of 20, result=20, timeout=0, busy=0.
REQ-034 With WATCHDOG_EN and MAX_CYCLES=1000, core_out toggles 0x155/0x2AA every cycle -> done=1, timeout=1, cycles=1000; without the macro -> still busy after 2000 cycles.
REQ-035 abort 10 cycles into RUN, with start asserted in the same cycle -> IDLE next cycle, core_reset=1, done=0, start ignored.
REQ-036 reset mid-RUN, then start -> all outputs at reset values, then a full RESET of 5 cycles before RUN resumes.
